div_ctrl: RTL

Multi-cycle divider sequencer for DIV/DIVU in the EX stage.
- Accepts operands from ex and runs a 32-step restoring division, one quotient bit per clock.
- Holds the pipeline via a stall request while busy.
- Presents {remainder, quotient} for ex to forward to ex_mem as hi/lo, and on to hilo_reg through mem/mem_wb.

---
 rtl/div_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider sequencer for DIV/DIVU, one quotient bit per clock.
// Define DIV_EARLY_EXIT_EN to finish early when |dividend| < |divisor|.
module div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     data1_i,
  input  logic [DATA_W-1:0]     data2_i,
  input  logic                  start_i,
  input  logic                  cancel_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stall_o
);

  localparam logic [1:0] ST_FREE    = 2'b00;
  localparam logic [1:0] ST_BY_ZERO = 2'b01;
  localparam logic [1:0] ST_ON      = 2'b10;
  localparam logic [1:0] ST_END     = 2'b11;

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W:0]     work_q, work_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic                  quo_neg_q, quo_neg_d;
  logic                  rem_neg_q, rem_neg_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic [DATA_W-1:0]     dividend_abs, divisor_abs;
  logic [2*DATA_W:0]     shifted, step;
  logic [DATA_W:0]       diff;
  logic                  early_exit;

  assign dividend_abs = (signed_i && data1_i[DATA_W-1]) ? -data1_i : data1_i;
  assign divisor_abs  = (signed_i && data2_i[DATA_W-1]) ? -data2_i : data2_i;

  // Upper W+1 bits always fit below 2*divisor, so diff's MSB is the borrow.
  assign shifted = {work_q[2*DATA_W-1:0], 1'b0};
  assign diff    = shifted[2*DATA_W:DATA_W] - {1'b0, divisor_q};
  assign step    = diff[DATA_W] ? shifted : {diff, shifted[DATA_W-1:1], 1'b1};

`ifdef DIV_EARLY_EXIT_EN
  assign early_exit = (cnt_q == '0) && (work_q[DATA_W-1:0] < divisor_q);
`else
  assign early_exit = 1'b0;
`endif

  function automatic logic [2*DATA_W-1:0] sign_fix(
    input logic [DATA_W-1:0] quo,
    input logic [DATA_W-1:0] rem,
    input logic              neg_quo,
    input logic              neg_rem
  );
    logic [DATA_W-1:0] quo_f, rem_f;
    quo_f = neg_quo ? -quo : quo;
    rem_f = neg_rem ? -rem : rem;
    return {rem_f, quo_f};
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      ST_FREE: begin
        if (start_i && !cancel_i) begin
          if (data2_i == '0) begin
            state_d = ST_BY_ZERO;
          end else begin
            work_d    = {{(DATA_W+1){1'b0}}, dividend_abs};
            divisor_d = divisor_abs;
            quo_neg_d = signed_i & (data1_i[DATA_W-1] ^ data2_i[DATA_W-1]);
            rem_neg_d = signed_i & data1_i[DATA_W-1];
            cnt_d     = '0;
            state_d   = ST_ON;
          end
        end
      end
      ST_BY_ZERO: begin
        state_d  = ST_END;
        ready_d  = 1'b1;
        result_d = '0;
      end
      ST_ON: begin
        if (early_exit) begin
          state_d  = ST_END;
          ready_d  = 1'b1;
          result_d = sign_fix('0, work_q[DATA_W-1:0], quo_neg_q, rem_neg_q);
        end else begin
          work_d = step;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d  = ST_END;
            ready_d  = 1'b1;
            result_d = sign_fix(step[DATA_W-1:0], step[2*DATA_W-1:DATA_W],
                                quo_neg_q, rem_neg_q);
          end
        end
      end
      default: begin
        if (!start_i) begin
          state_d  = ST_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
    endcase
    // A flush beats both a held start and a completing step.
    if (cancel_i && state_q != ST_FREE) begin
      state_d  = ST_FREE;
      ready_d  = 1'b0;
      result_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign stall_o  = (state_q == ST_FREE && start_i && !cancel_i) ||
                    (state_q == ST_BY_ZERO) || (state_q == ST_ON);
  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
